// File: rtl/spi_ram_sender_pkg.sv
// Shared types and constants for the SPI RAM sender: FSM state encoding and
// the widths of the half-period/tail counter and the bit counter.
package spi_ram_sender_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_TAIL
    } state_e;

    localparam int CNT_W = 8;
    localparam int BIT_W = 3;

    // Reload value for the down-counter so that a phase lasts exactly div cycles.
    function automatic logic [CNT_W-1:0] half_load(input int div);
        return CNT_W'(div - 1);
    endfunction

endpackage

// File: rtl/spi_ram_sender.sv
// SPI master (CPOL=0, MSB first) streaming SRAM bytes 0..len-1 over SCLK/CS_N/MOSI.
// All outputs come straight from registers updated in one FSM process.
module spi_ram_sender
    import spi_ram_sender_pkg::*;
#(
    parameter int AW  = 8,
    parameter int DIV = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW:0]   i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_sram_raddr,
    output logic          o_sram_ren,
    input  logic [7:0]    i_sram_rdata,
    output logic          o_sclk,
    output logic          o_cs_n,
    output logic          o_mosi
);

    localparam logic [CNT_W-1:0] HALF_LOAD = half_load(DIV);
    localparam logic [BIT_W-1:0] LAST_BIT  = '1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [AW:0]      addr_q;
    logic [AW:0]      len_q;
    logic [7:0]       sr_q;
    logic             cs_n_q;
    logic             sclk_q;
    logic             busy_q;
    logic             done_q;
    logic             ren_q;
    logic [AW-1:0]    raddr_q;

    logic [AW:0]      addr_d;
    logic             last_byte_d;
    logic             cnt_tc_d;

    assign addr_d      = addr_q + (AW+1)'(1);
    assign last_byte_d = (addr_q == len_q - (AW+1)'(1));
    assign cnt_tc_d    = (cnt_q == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            sr_q      <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ren_q     <= 1'b0;
            raddr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            len_q   <= i_len;
                            addr_q  <= '0;
                            raddr_q <= '0;
                            ren_q   <= 1'b1;
                            cs_n_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_FETCH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    ren_q   <= 1'b0;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    // MOSI is sr_q[7], so capturing here presents bit 7 in the first LOW.
                    sr_q      <= i_sram_rdata;
                    bit_cnt_q <= '0;
                    cnt_q     <= HALF_LOAD;
                    state_q   <= ST_LOW;
                end
                ST_LOW: begin
                    if (cnt_tc_d) begin
                        cnt_q   <= HALF_LOAD;
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_tc_d) begin
                        cnt_q  <= HALF_LOAD;
                        sclk_q <= 1'b0;
                        if (bit_cnt_q != LAST_BIT) begin
                            sr_q      <= {sr_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            state_q   <= ST_LOW;
                        end else if (!last_byte_d) begin
                            addr_q  <= addr_d;
                            raddr_q <= addr_d[AW-1:0];
                            ren_q   <= 1'b1;
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_TAIL;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_TAIL: begin
                    if (cnt_tc_d) begin
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        sr_q    <= '0;
                        raddr_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ren_q   <= 1'b0;
                    sr_q    <= '0;
                end
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_sram_raddr = raddr_q;
    assign o_sram_ren   = ren_q;
    assign o_sclk       = sclk_q;
    assign o_cs_n       = cs_n_q;
    assign o_mosi       = sr_q[7];

endmodule
